// File: rtl/mux4_bus_arbiter.sv
// Round-robin 4-way bus arbiter: MAX_HOLD tenure cap, one idle turnaround cycle between grants.
// Latency: req seen in IDLE -> registered gnt/sel next cycle; requesters hold req level, no queuing.
module mux4_bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       preempt_o
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic          busy_q;
  logic          preempt_q;
  logic [CW-1:0] hold_cnt_q;
  logic [1:0]    last_q;

  logic          win_vld_d;
  logic [1:0]    win_idx_d;
  logic [1:0]    cand_d;

  // Scan from furthest to nearest so the candidate closest after last_q wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = last_q;
    cand_d    = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand_d = last_q + 2'(k);
      if (req_i[cand_d]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= 2'd3;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q    <= BUSY;
            gnt_q      <= 4'b0001 << win_idx_d;
            sel_q      <= win_idx_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        BUSY: begin
          if (!req_i[sel_q]) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            last_q  <= sel_q;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            last_q    <= sel_q;
            preempt_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign busy_o    = busy_q;
  assign preempt_o = preempt_q;

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Randomized + directed bench for mux4_bus_arbiter against a tenure-level reference model.
module tb_mux4_bus_arbiter;
  localparam int MAX_HOLD = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = 4'hF;
  logic [3:0] gnt_o;
  logic [1:0] sel_o;
  logic       busy_o;
  logic       preempt_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: who owns the bus (-1 = nobody), how many cycles they have held it.
  int m_owner, m_cnt, m_last, m_sel;
  bit m_pre;

  mux4_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
    .gnt_o(gnt_o), .sel_o(sel_o), .busy_o(busy_o), .preempt_o(preempt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 3; m_sel = 0; m_pre = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int idx;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx; m_sel = idx; m_cnt = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end else if (m_cnt == MAX_HOLD) begin
      m_last = m_owner; m_owner = -1; m_pre = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic int exp_gnt();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("model_gnt", int'(gnt_o), exp_gnt());
      chk("model_sel", int'(sel_o), m_sel);
      chk("model_busy", int'(busy_o), (m_owner >= 0) ? 1 : 0);
      chk("model_preempt", int'(preempt_o), int'(m_pre));
      chk("inv_onehot0", int'($onehot0(gnt_o)), 1);
      chk("inv_busy_or", int'(busy_o), int'(|gnt_o));
      if (busy_o) chk("inv_gnt_sel", int'(gnt_o[sel_o]), 1);
    end
  end

  // Drive one cycle: req applied at negedge, sampled at posedge, returns at next negedge.
  task automatic cyc(input logic [3:0] r);
    req_i = r;
    @(posedge clk_i);
    model_step(r);
    @(negedge clk_i);
  endtask

  task automatic pulse_reset();
    #2;
    rst_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  logic [3:0] r;

  initial begin
    model_reset();
    chk_en = 1'b1;
    // Reset with all requesting
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_sel", int'(sel_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_preempt", int'(preempt_o), 0);
    rst_i = 1'b0;
    cyc(4'hF);
    chk("rst_release_gnt", int'(gnt_o), 1);
    cyc(4'h0);

    // Single short request to 2
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100);
      chk("short_gnt", int'(gnt_o), 4);
      chk("short_sel", int'(sel_o), 2);
      chk("short_preempt", int'(preempt_o), 0);
    end
    cyc(4'h0);
    chk("short_idle_gnt", int'(gnt_o), 0);
    chk("short_idle_sel", int'(sel_o), 2);
    chk("short_idle_preempt", int'(preempt_o), 0);

    // Expiry: requester 1 holds 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0010);
      if (i < 8) chk("exp_gnt_hold", int'(gnt_o), 2);
      if (i == 8) begin
        chk("exp_idle_gnt", int'(gnt_o), 0);
        chk("exp_preempt", int'(preempt_o), 1);
        chk("exp_idle_sel", int'(sel_o), 1);
      end
      if (i == 9) begin
        chk("exp_regrant", int'(gnt_o), 2);
        chk("exp_preempt_clr", int'(preempt_o), 0);
      end
    end
    cyc(4'h0);

    // Rotation from reset: 0,1,2,3,0 with 8-cycle tenures and 1 idle
    pulse_reset();
    for (int i = 0; i < 45; i++) begin
      cyc(4'hF);
      if (i % 9 < 8) begin
        chk("rot_gnt", int'(gnt_o), 1 << ((i / 9) % 4));
      end else begin
        chk("rot_idle_gnt", int'(gnt_o), 0);
        chk("rot_idle_preempt", int'(preempt_o), 1);
      end
      chk("rot_sel", int'(sel_o), (i / 9) % 4);
    end
    cyc(4'h0);

    // Skip pattern: last=1, req=1001 -> 3, then after expiry -> 0
    cyc(4'b0010);
    cyc(4'h0);
    cyc(4'b1001);
    chk("skip_first", int'(gnt_o), 8);
    for (int i = 0; i < 8; i++) cyc(4'b1001);
    chk("skip_turnaround", int'(gnt_o), 0);
    cyc(4'b1001);
    chk("skip_second", int'(gnt_o), 1);
    cyc(4'h0);

    // Async reset in the 4th cycle of a grant to 2
    for (int i = 0; i < 4; i++) cyc(4'b0100);
    chk("async_pre_gnt", int'(gnt_o), 4);
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    chk("async_gnt_drop", int'(gnt_o), 0);
    chk("async_busy_drop", int'(busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc(4'b0100);
    chk("async_regrant", int'(gnt_o), 4);
    cyc(4'h0);

    // Randomized traffic with sticky requests and occasional resets
    r = 4'h0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else cyc(r);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
